// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/subtract-and-shift step per clock,
// signed or unsigned WIDTH x WIDTH operands, start/ready/done handshake.
module seq_booth_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // state | meaning
  // IDLE  | waiting for start, ready=1
  // CALC  | one Booth step per clock, WIDTH+1 steps
  // DONE  | one-cycle done pulse, ready=1, start accepted back-to-back
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t               state;
  logic [WIDTH+1:0]     acc;
  logic [WIDTH:0]       mcand;
  logic [WIDTH:0]       mplier;
  logic                 q_m1;
  logic [CW-1:0]        count;

  logic [WIDTH+1:0]     m_ext;
  logic [WIDTH+1:0]     sum;
  logic [2*WIDTH+3:0]   shifted;

  // Two guard bits on the accumulator keep A-M exact even for the most-negative M.
  always_comb begin
    m_ext = {mcand[WIDTH], mcand};
    case ({mplier[0], q_m1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
    shifted = {sum[WIDTH+1], sum, mplier};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          ready <= 1'b1;
          state <= IDLE;
          if (start) begin
            mcand  <= is_signed ? {m[WIDTH-1], m} : {1'b0, m};
            mplier <= is_signed ? {q[WIDTH-1], q} : {1'b0, q};
            acc    <= '0;
            q_m1   <= 1'b0;
            count  <= '0;
            ready  <= 1'b0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= shifted[2*WIDTH+3:WIDTH+2];
          mplier <= shifted[WIDTH+1:1];
          q_m1   <= shifted[0];
          count  <= count + 1'b1;
          if (count == CW'(WIDTH)) begin
            product <= shifted[2*WIDTH:1];
            done    <= 1'b1;
            ready   <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Scoreboard bench for seq_booth_multiplier: directed 8-bit vectors plus a
// 16-bit corner/random sweep checked against a behavioural product.
module tb_seq_booth_multiplier;

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset_n;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic        start8, signed8, ready8, done8;
  logic [7:0]  m8, q8;
  logic [15:0] product8;

  logic        start16, signed16, ready16, done16;
  logic [15:0] m16, q16;
  logic [31:0] product16;

  sb_t sb8[$];
  sb_t sb16[$];
  int  last_acc8;

  seq_booth_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .is_signed(signed8),
    .m(m8), .q(q8), .ready(ready8), .done(done8), .product(product8)
  );

  seq_booth_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .is_signed(signed16),
    .m(m16), .q(q16), .ready(ready16), .done(done16), .product(product16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitors: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done8) begin
      if (sb8.size() == 0) begin
        checks++; errors++;
        $display("FAIL w8 unexpected done: product %h", product8);
      end else begin
        sb_t e;
        e = sb8.pop_front();
        check("w8 product", {16'h0, product8}, e.exp);
        check("w8 latency", cyc - e.acc, 32'd9);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && done16) begin
      if (sb16.size() == 0) begin
        checks++; errors++;
        $display("FAIL w16 unexpected done: product %h", product16);
      end else begin
        sb_t e;
        e = sb16.pop_front();
        check("w16 product", product16, e.exp);
        check("w16 latency", cyc - e.acc, 32'd17);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue8(input logic s, input logic [7:0] mm, input logic [7:0] qq,
                        input logic [15:0] ex, input bit keep, input bit push);
    int n = 0;
    signed8 = s; m8 = mm; q8 = qq; start8 = 1'b1;
    while (!ready8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready8) begin
      checks++; errors++;
      $display("FAIL w8 accept timeout: ready %b expected 1", ready8);
    end
    @(posedge clk);
    #1;
    last_acc8 = cyc;
    if (push) sb8.push_back('{exp: {16'h0, ex}, acc: cyc});
    @(negedge clk);
    if (!keep) start8 = 1'b0;
  endtask

  task automatic issue16(input logic s, input logic [15:0] mm, input logic [15:0] qq,
                         input logic [31:0] ex);
    int n = 0;
    signed16 = s; m16 = mm; q16 = qq; start16 = 1'b1;
    while (!ready16 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready16) begin
      checks++; errors++;
      $display("FAIL w16 accept timeout: ready %b expected 1", ready16);
    end
    @(posedge clk);
    #1;
    sb16.push_back('{exp: ex, acc: cyc});
    @(negedge clk);
  endtask

  task automatic drain8();
    int n = 0;
    while (sb8.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb8.size() != 0) begin
      checks++; errors++;
      $display("FAIL w8 drain timeout: pending %0d expected 0", sb8.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic drain16();
    int n = 0;
    while (sb16.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb16.size() != 0) begin
      checks++; errors++;
      $display("FAIL w16 drain timeout: pending %0d expected 0", sb16.size());
    end
    repeat (3) @(negedge clk);
  endtask

  logic [15:0] corners[5];
  initial begin
    int a0;
    logic [15:0] a, b;
    logic s;
    logic [31:0] ex;

    corners = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0001, 16'hFFFF};
    reset_n = 1'b0;
    start8 = 0; signed8 = 0; m8 = 0; q8 = 0;
    start16 = 0; signed16 = 0; m16 = 0; q16 = 0;
    repeat (3) @(negedge clk);
    check("reset ready", {31'h0, ready8}, 32'd1);
    check("reset done", {31'h0, done8}, 32'd0);
    check("reset product", {16'h0, product8}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Signed corners, including most-negative squared.
    issue8(1, 8'h80, 8'h80, 16'h4000, 0, 1); drain8();
    issue8(1, 8'h7F, 8'h80, 16'hC080, 0, 1); drain8();
    issue8(1, 8'hFD, 8'h05, 16'hFFF1, 0, 1); drain8();
    // Same bit patterns, unsigned vs signed.
    issue8(0, 8'hFF, 8'hFF, 16'hFE01, 0, 1); drain8();
    issue8(0, 8'h80, 8'h02, 16'h0100, 0, 1); drain8();
    issue8(1, 8'hFF, 8'hFF, 16'h0001, 0, 1); drain8();
    issue8(1, 8'h80, 8'h02, 16'hFF00, 0, 1); drain8();

    // Start while busy is ignored; product holds old result during CALC.
    issue8(0, 8'd5, 8'd7, 16'h0023, 0, 1);
    check("busy ready", {31'h0, ready8}, 32'd0);
    check("product hold", {16'h0, product8}, 32'h0000FF00);
    start8 = 1'b1; m8 = 8'd3; q8 = 8'd3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      check("busy ready", {31'h0, ready8}, 32'd0);
    end
    drain8();

    // Back-to-back with start held high.
    begin
      int first;
      issue8(1, 8'd2, 8'd3, 16'h0006, 1, 1);
      first = last_acc8;
      issue8(1, 8'hFC, 8'd6, 16'hFFE8, 0, 1);
      check("b2b spacing", last_acc8 - first, 32'd10);
    end
    drain8();

    // Reset mid-calculation aborts with no done.
    issue8(0, 8'h12, 8'h34, 16'h0000, 0, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort ready", {31'h0, ready8}, 32'd1);
    check("abort product", {16'h0, product8}, 32'h0);
    check("abort done", {31'h0, done8}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    issue8(0, 8'd9, 8'd9, 16'h0051, 0, 1); drain8();

    // 16-bit: all corner pairs in both modes, then random vectors back-to-back.
    for (int i = 0; i < 1000; i++) begin
      if (i < 50) begin
        s = (i / 25) != 0;
        a = corners[(i % 25) / 5];
        b = corners[i % 5];
      end else begin
        s = $urandom_range(0, 1) != 0;
        a = 16'($urandom);
        b = 16'($urandom);
      end
      if (s) begin
        a0 = int'($signed(a)) * int'($signed(b));
        ex = a0;
      end else begin
        ex = {16'h0, a} * {16'h0, b};
      end
      issue16(s, a, b, ex);
    end
    start16 = 1'b0;
    drain16();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
